// File: rtl/spi_reg_peripheral.sv
// SPI mode-0 register-file peripheral: synchronised pins, command/data framing,
// atomic write commit on nCS release and register read-back on CIPO.
module spi_reg_peripheral #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       SCLK,
    input  logic                       nCS,
    input  logic                       COPI,
    output logic                       CIPO,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_out,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);

    localparam int FRAME = 1 + ADDR_W + DATA_W;
    localparam int CW    = $clog2(FRAME + 2);
    localparam int SW    = $clog2(SYNC_STAGES + 3);

    localparam logic [CW-1:0]   FRAME_C    = CW'(FRAME);
    localparam logic [CW-1:0]   CNT_MAX    = CW'(FRAME + 1);
    localparam logic [CW-1:0]   LAST_CMD   = CW'(ADDR_W);
    localparam logic [SW-1:0]   SETTLE_MAX = SW'(SYNC_STAGES + 2);
    localparam logic [ADDR_W:0] NUM_REGS_C = (ADDR_W + 1)'(NUM_REGS);

    typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, WAIT_CS} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, ncs_sync_q, copi_sync_q;
    logic                   sclk_prev_q, ncs_prev_q;
    logic [SW-1:0]          settle_q;

    state_t              state_q, state_d;
    logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0]   cmd_q, cmd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wr_shift_q, wr_shift_d;
    logic [DATA_W-1:0]   rd_shift_q, rd_shift_d;
    logic                cipo_q, cipo_d;
    logic                oe_q, oe_d;
    logic                wr_strobe_q, wr_strobe_d;
    logic                frame_err_q, frame_err_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];

    logic              sclk_s, ncs_s, copi_s;
    logic              sclk_rise, sclk_fall, ncs_rise, ncs_fall;
    logic              settling, addr_ok, commit;
    logic [ADDR_W:0]   cmd_full;
    logic [DATA_W:0]   wr_full;
    logic [DATA_W-1:0] rd_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            ncs_sync_q  <= '1;
            copi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            ncs_prev_q  <= 1'b1;
            settle_q    <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], nCS};
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], COPI};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            ncs_prev_q  <= ncs_sync_q[SYNC_STAGES-1];
            if (settle_q != SETTLE_MAX) settle_q <= settle_q + SW'(1);
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
    assign copi_s    = copi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign ncs_rise  = ncs_s & ~ncs_prev_q;
    assign ncs_fall  = ~ncs_s & ncs_prev_q;

    // The sync chain resets to nCS idle, so a chip select already held low at
    // reset release shows up as a fall while this window is still open.
    assign settling = (settle_q != SETTLE_MAX);

    assign cmd_full = {cmd_q, copi_s};
    assign wr_full  = {wr_shift_q, copi_s};
    assign addr_ok  = ({1'b0, addr_q} < NUM_REGS_C);

    always_comb begin
        rd_val = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (cmd_full[ADDR_W-1:0] == ADDR_W'(i)) rd_val = regs_q[i];
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        wr_shift_d  = wr_shift_q;
        rd_shift_d  = rd_shift_q;
        cipo_d      = cipo_q;
        oe_d        = oe_q;
        wr_strobe_d = 1'b0;
        frame_err_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        commit      = 1'b0;
        unique case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                if (ncs_fall) state_d = settling ? WAIT_CS : CMD;
            end
            WAIT_CS: begin
                if (ncs_rise) state_d = IDLE;
            end
            CMD, WDATA, RDATA: begin
                if (ncs_rise) begin
                    state_d = IDLE;
                    cipo_d  = 1'b0;
                    oe_d    = 1'b0;
                    if (state_q == WDATA && bit_cnt_q == FRAME_C && addr_ok) begin
                        commit      = 1'b1;
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = addr_q;
                    end else if (state_q != RDATA || !addr_ok || bit_cnt_q < FRAME_C) begin
                        frame_err_d = 1'b1;
                    end
                end else if (!ncs_s && sclk_rise) begin
                    bit_cnt_d = (bit_cnt_q == CNT_MAX) ? bit_cnt_q : bit_cnt_q + CW'(1);
                    if (state_q == CMD) begin
                        cmd_d = cmd_full[ADDR_W-1:0];
                        if (bit_cnt_q == LAST_CMD) begin
                            addr_d = cmd_full[ADDR_W-1:0];
                            if (cmd_full[ADDR_W]) begin
                                state_d = WDATA;
                            end else begin
                                state_d    = RDATA;
                                rd_shift_d = rd_val;
                            end
                        end
                    end else if (state_q == WDATA) begin
                        wr_shift_d = wr_full[DATA_W-1:0];
                    end
                end else if (!ncs_s && sclk_fall && state_q == RDATA) begin
                    cipo_d     = rd_shift_q[DATA_W-1];
                    oe_d       = 1'b1;
                    rd_shift_d = rd_shift_q << 1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        regs_d = regs_q;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (commit && addr_q == ADDR_W'(i)) regs_d[i] = wr_shift_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            cmd_q       <= '0;
            addr_q      <= '0;
            wr_shift_q  <= '0;
            rd_shift_q  <= '0;
            cipo_q      <= 1'b0;
            oe_q        <= 1'b0;
            wr_strobe_q <= 1'b0;
            frame_err_q <= 1'b0;
            wr_addr_q   <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            wr_shift_q  <= wr_shift_d;
            rd_shift_q  <= rd_shift_d;
            cipo_q      <= cipo_d;
            oe_q        <= oe_d;
            wr_strobe_q <= wr_strobe_d;
            frame_err_q <= frame_err_d;
            wr_addr_q   <= wr_addr_d;
            regs_q      <= regs_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign regs_out[g*DATA_W +: DATA_W] = regs_q[g];
    end

    assign CIPO      = cipo_q;
    assign cipo_oe   = oe_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Bench for spi_reg_peripheral: default and wide instances share the SPI pins;
// a table of frames plus a hand-written mid-frame reset sequence.
module tb_spi_reg_peripheral;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk = 1'b0;
    logic ncs = 1'b1;
    logic copi = 1'b0;

    logic         cipo1, oe1, stb1, err1;
    logic [39:0]  regs1;
    logic [6:0]   wa1;
    logic         cipo2, oe2, stb2, err2;
    logic [255:0] regs2;
    logic [3:0]   wa2;

    always #5 clk = ~clk;

    spi_reg_peripheral u_dut1 (
        .clk(clk), .rst(rst), .SCLK(sclk), .nCS(ncs), .COPI(copi),
        .CIPO(cipo1), .cipo_oe(oe1), .regs_out(regs1),
        .wr_strobe(stb1), .wr_addr(wa1), .frame_err(err1)
    );

    spi_reg_peripheral #(.ADDR_W(4), .DATA_W(16), .NUM_REGS(16), .SYNC_STAGES(2)) u_dut2 (
        .clk(clk), .rst(rst), .SCLK(sclk), .nCS(ncs), .COPI(copi),
        .CIPO(cipo2), .cipo_oe(oe2), .regs_out(regs2),
        .wr_strobe(stb2), .wr_addr(wa2), .frame_err(err2)
    );

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t          q1[$];
    wr_t          q2[$];
    logic [39:0]  m1 = '0;
    logic [255:0] m2 = '0;
    int n_stb1 = 0, n_err1 = 0, n_stb2 = 0, n_err2 = 0;

    // Scoreboard: each committed write must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst) begin
            if (err1) n_err1++;
            if (err2) n_err2++;
            if (stb1) begin
                wr_t e;
                n_stb1++;
                if (q1.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_wr_strobe1: wr_addr=%0h, no write expected", wa1);
                end else begin
                    e = q1.pop_front();
                    check("wr_addr1", 256'(wa1), 256'(e.addr));
                    check("commit_reg1", 256'(regs1[e.addr*8 +: 8]), 256'(e.data[7:0]));
                end
            end
            if (stb2) begin
                wr_t e;
                n_stb2++;
                if (q2.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_wr_strobe2: wr_addr=%0h, no write expected", wa2);
                end else begin
                    e = q2.pop_front();
                    check("wr_addr2", 256'(wa2), 256'(e.addr));
                    check("commit_reg2", 256'(regs2[e.addr*16 +: 16]), 256'(e.data));
                end
            end
        end
    end

    task automatic spi_bit(input logic b, input bit sel, output logic s_cipo, output logic s_oe);
        copi = b;
        repeat (6) @(negedge clk);
        s_cipo = sel ? cipo2 : cipo1;
        s_oe   = sel ? oe2 : oe1;
        sclk = 1'b1;
        repeat (6) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic spi_frame(input bit sel, input logic [31:0] bits, input int n,
                             output logic [31:0] rd, output int oe_ones);
        logic c, o;
        rd = '0;
        oe_ones = 0;
        ncs = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            spi_bit(bits[n-1-i], sel, c, o);
            rd = {rd[30:0], c};
            if (o) oe_ones++;
        end
        repeat (6) @(negedge clk);
        ncs = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    typedef struct {
        bit          sel;
        logic [31:0] frame;
        int          n;
        bit          stb;
        bit          err;
        bit          rd_chk;
        logic [15:0] rd_exp;
    } vec_t;

    task automatic run_vec(input vec_t v, input int idx);
        int   s0, e0, ones, exp_ones, cmd_bits;
        logic [31:0] rd;
        wr_t  w;
        string tag;
        tag = $sformatf("v%0d", idx);
        cmd_bits = v.sel ? 5 : 8;
        exp_ones = (!v.frame[v.n-1] && v.n > cmd_bits) ? v.n - cmd_bits : 0;
        s0 = v.sel ? n_stb2 : n_stb1;
        e0 = v.sel ? n_err2 : n_err1;
        if (v.stb) begin
            if (v.sel) begin
                w.addr = 16'(v.frame[19:16]);
                w.data = v.frame[15:0];
                q2.push_back(w);
                m2[w.addr*16 +: 16] = w.data;
            end else begin
                w.addr = 16'(v.frame[14:8]);
                w.data = 16'(v.frame[7:0]);
                q1.push_back(w);
                m1[w.addr*8 +: 8] = w.data[7:0];
            end
        end
        spi_frame(v.sel, v.frame, v.n, rd, ones);
        check({tag, "_strobes"}, 256'((v.sel ? n_stb2 : n_stb1) - s0), 256'(v.stb));
        check({tag, "_frame_err"}, 256'((v.sel ? n_err2 : n_err1) - e0), 256'(v.err));
        check({tag, "_oe_cycles"}, 256'(ones), 256'(exp_ones));
        if (v.sel) check({tag, "_regs2"}, regs2, m2);
        else       check({tag, "_regs1"}, 256'(regs1), 256'(m1));
        if (v.rd_chk) begin
            if (v.sel) check({tag, "_rdata"}, 256'(rd[15:0]), 256'(v.rd_exp));
            else       check({tag, "_rdata"}, 256'(rd[7:0]), 256'(v.rd_exp[7:0]));
        end
        check({tag, "_idle_cipo_oe"}, 256'({v.sel ? cipo2 : cipo1, v.sel ? oe2 : oe1}), 256'(0));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_regs1"}, 256'(regs1), 256'(0));
        check({tag, "_regs2"}, regs2, 256'(0));
        check({tag, "_outs1"}, 256'({cipo1, oe1, stb1, err1, wa1}), 256'(0));
        check({tag, "_outs2"}, 256'({cipo2, oe2, stb2, err2, wa2}), 256'(0));
    endtask

    vec_t tv[18];

    initial begin
        logic c, o;
        logic [15:0] rf;
        int s0;

        tv[0]  = '{0, 32'h84A5,   16, 1, 0, 1'b0, 16'h0};
        tv[1]  = '{0, 32'h823C,   16, 1, 0, 1'b0, 16'h0};
        tv[2]  = '{0, 32'h0200,   16, 0, 0, 1'b1, 16'h3C};
        tv[3]  = '{0, 32'h90FF,   16, 0, 1, 1'b0, 16'h0};
        tv[4]  = '{0, 32'h1000,   16, 0, 1, 1'b1, 16'h00};
        tv[5]  = '{0, 32'h205,    10, 0, 1, 1'b0, 16'h0};
        tv[6]  = '{0, 32'h10355,  17, 0, 1, 1'b0, 16'h0};
        tv[7]  = '{0, 32'h0100,   16, 0, 0, 1'b1, 16'h00};
        tv[8]  = '{0, 32'h0400,   16, 0, 0, 1'b1, 16'hA5};
        tv[9]  = '{0, 32'h8199,   16, 1, 0, 1'b0, 16'h0};
        tv[10] = '{0, 32'h0100,   16, 0, 0, 1'b1, 16'h99};
        tv[11] = '{0, 32'h020,    12, 0, 1, 1'b0, 16'h0};
        tv[12] = '{0, 32'h0800,   18, 0, 0, 1'b0, 16'h0};
        tv[13] = '{0, 32'h8012,   16, 1, 0, 1'b0, 16'h0};
        tv[14] = '{1, 32'h13BEEF, 21, 1, 0, 1'b0, 16'h0};
        tv[15] = '{1, 32'h030000, 21, 0, 0, 1'b1, 16'hBEEF};
        tv[16] = '{1, 32'h1F1234, 21, 1, 0, 1'b0, 16'h0};
        tv[17] = '{1, 32'h0F0000, 21, 0, 0, 1'b1, 16'h1234};

        repeat (4) @(negedge clk);
        check_reset_state("por");
        rst = 1'b0;
        repeat (8) @(negedge clk);

        for (int i = 0; i < 18; i++) run_vec(tv[i], i);

        // Reset six bits into a write to reg0, released with nCS still low.
        rf = 16'h80AA;
        s0 = n_stb1;
        ncs = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 6; i++) spi_bit(rf[15-i], 1'b0, c, o);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_state("midrst");
        m1 = '0;
        m2 = '0;
        rst = 1'b0;
        for (int i = 6; i < 16; i++) spi_bit(rf[15-i], 1'b0, c, o);
        repeat (6) @(negedge clk);
        ncs = 1'b1;
        repeat (10) @(negedge clk);
        check("midrst_no_strobe", 256'(n_stb1 - s0), 256'(0));
        check("midrst_regs1", 256'(regs1), 256'(0));

        run_vec('{0, 32'h8055,   16, 1, 0, 1'b0, 16'h0}, 18);
        run_vec('{0, 32'h0000,   16, 0, 0, 1'b1, 16'h55}, 19);
        run_vec('{1, 32'h030000, 21, 0, 0, 1'b1, 16'h0000}, 20);

        check("sb_empty1", 256'(q1.size()), 256'(0));
        check("sb_empty2", 256'(q2.size()), 256'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/spi_reg_peripheral.md
Name: spi_reg_peripheral

Overview:
Parametrised SPI mode-0 register-file peripheral. It is the successor to the fixed 5-register, write-only SPI control block. It adds configurable address width, data width and register count, and supports register read-back on CIPO. It detects malformed frames and commits writes atomically on nCS release. The block sits between the chip pins (SCLK/nCS/COPI/CIPO) and the PWM/output-enable logic, which consumes regs_out.

Parameters:
ADDR_W, 7, address field width in bits; frame = 1 + ADDR_W + DATA_W bits
DATA_W, 8, register and data field width
NUM_REGS, 5, number of implemented registers (1..2^ADDR_W)
SYNC_STAGES, 2, synchroniser flops on SCLK/nCS/COPI (min 2)

Ports:
clk  in  1  system clock; sole clock domain
rst  in  1  synchronous, active-high reset
SCLK  in  1  SPI clock, async, idle low (mode 0)
nCS  in  1  chip select, async, active low
COPI  in  1  controller-out data, async, MSB first
CIPO  out  1  peripheral-out read data
cipo_oe  out  1  high while a read data phase is active; drives pad tristate
regs_out  out  NUM_REGS*DATA_W  flattened registers; reg i at [i*DATA_W +: DATA_W]
wr_strobe  out  1  one-clk pulse when a write commits
wr_addr  out  ADDR_W  address of last committed write
frame_err  out  1  one-clk pulse when a frame is discarded

Behaviour:
- Reset (rst=1 at posedge clk): regs_out=0, CIPO=0, cipo_oe=0, wr_strobe=0, wr_addr=0, frame_err=0. Sync chains are set to idle (SCLK=0, nCS=1). FSM goes to IDLE and the counters clear. A frame in progress is lost.
- Inputs pass through SYNC_STAGES flops. An edge is detected by comparing the last stage with one extra flop. sclk_rise and sclk_fall are single-clk pulses; ncs_fall and ncs_rise likewise.
- Frame format, MSB first: bit0 is R/W (1=write, 0=read), then ADDR_W address bits, then DATA_W data bits. COPI is sampled on sclk_rise. CIPO changes on sclk_fall.
- bit_cnt counts sclk_rise while nCS is low and saturates at FRAME+1. Any value above FRAME marks the frame over-length.
- FSM states:
  - IDLE: wait for ncs_fall, then go to CMD with bit_cnt=0.
  - CMD: shift 1+ADDR_W bits. On the last address bit: a write goes to WDATA; a read goes to RDATA and, in the same clk, loads rd_shift with reg[addr] (0 if addr>=NUM_REGS).
  - WDATA: shift DATA_W bits into wr_shift. Bits beyond the frame set the over-length flag.
  - RDATA: on the first sclk_fall, cipo_oe=1 and CIPO=rd_shift MSB. Each later sclk_fall shifts left. COPI bits are ignored.
  - WAIT_CS: entered from IDLE-after-reset if nCS is already low. Ignores all activity until ncs_rise, then goes to IDLE.
- ncs_rise in CMD/WDATA/RDATA ends the frame:
  - Valid write (write, bit_cnt==FRAME exactly, addr<NUM_REGS): reg[addr]<=data, wr_addr<=addr, wr_strobe=1, all on the ncs_rise detect clk. regs_out is visible the following clk.
  - Write with a short frame, an over-length frame, or addr>=NUM_REGS: no register change, frame_err=1.
  - Read: no register change. frame_err=1 only if addr>=NUM_REGS or the frame is short.
  - On ncs_rise: cipo_oe=0 and CIPO=0. FSM returns to IDLE.
- Simultaneous events: ncs_rise wins over sclk_rise/sclk_fall in the same clk; that SCLK edge is ignored. SCLK edges while synced nCS is high are ignored.
- Only one register is written per frame. No burst or auto-increment. The write is atomic; a partial frame never alters regs_out.
- Read of reg[addr] returns the value held at the address-complete instant. A write committing in the same frame cannot occur (one R/W per frame).
- Timing constraint: SCLK high and low phases each ≥ SYNC_STAGES+2 clk periods.

Test Plan:
- Defaults, frame 1_0000100_10100101 (0x84A5) -> reg4=0xA5, wr_strobe 1 clk, wr_addr=4, frame_err=0, other regs 0.
- Write reg2=0x3C, then read frame 0_0000010_xxxxxxxx -> cipo_oe high during the data phase, CIPO bits 0,0,1,1,1,1,0,0 on successive falling edges, regs unchanged.
- Write frame with addr 0x10 (≥NUM_REGS), data 0xFF -> no reg change, frame_err pulse, no wr_strobe; read of 0x10 -> CIPO returns 0x00 and frame_err pulses.
- Short write (10 bits) and over-length write (17 bits, valid addr 1) -> reg1 unchanged, one frame_err pulse per frame.
- rst asserted after 6 bits of a write to reg0, released with nCS still low, remaining bits clocked -> regs_out all 0, no wr_strobe. The next full frame 0x8055 -> reg0=0x55.
- ADDR_W=4, DATA_W=16, NUM_REGS=16: write 0x1_3_BEEF (21-bit frame) -> reg3=0xBEEF; readback of reg3 returns 0xBEEF MSB first.
